// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice: FSM state
// encoding, legal oversample ratios, the per-byte error record and the
// even-parity check helper.
package uart_pkg;

  // Legal oversample ratios (ticks per bit)
  localparam int OVS_8  = 8;
  localparam int OVS_16 = 16;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_rx_state_e;

  // Error flags captured alongside a received byte
  typedef struct packed {
    logic parity;
    logic frame;
  } uart_rx_err_t;

  // Even parity: the eight data bits plus the parity bit must XOR to 0
  function automatic logic even_par_err(input logic [7:0] data, input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..clk_div_i and emits one tick per
// wrap. The divisor is captured at each reload, so a new clk_div_i only
// affects the period after the current one. clear_i restarts the count so
// the bit timing lines up with a detected start edge.
module uart_baud_tick #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             clear_i,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_r;
  logic             tick_r;

  // Divider counter with reload-time divisor capture and registered tick
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r  <= {DIV_W{1'b0}};
      div_r  <= {DIV_W{1'b0}};
      tick_r <= 1'b0;
    end else if (clear_i) begin
      cnt_r  <= {DIV_W{1'b0}};
      div_r  <= clk_div_i;
      tick_r <= 1'b0;
    end else if (cnt_r == div_r) begin
      cnt_r  <= {DIV_W{1'b0}};
      div_r  <= clk_div_i;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CNT_ONE;
      tick_r <= 1'b0;
    end
  end

  assign tick_o = tick_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop line synchroniser, oversampled 3-sample majority
// voting, optional even parity and a single-entry holding register with
// valid/ready handshake, break and overrun pulses.
// Optional feature macro: UART_RX_PARITY_EN (parity checking compiled in).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             rx_enable_i,
  input  logic             parity_en_i,
  input  logic             rx_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             break_o,
  output logic             overrun_o
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_ONE  = {{(SW-1){1'b0}}, 1'b1};

  uart_rx_state_e state_r, state_s;
  logic         rx_meta_r, rx_sync_r, rx_prev_r;
  logic [SW-1:0] samp_cnt_r;
  logic [2:0]   bit_cnt_r;
  logic [7:0]   shift_r;
  logic         smp_a_r, smp_b_r;
  logic         par_en_r, par_err_r;
  logic [7:0]   data_r;
  uart_rx_err_t hold_err_r;
  logic         valid_r, break_r, overrun_r;

  logic tick_s, start_edge_s, maj_tick_s, bit_end_s, maj_s;
  logic frame_done_s, par_en_s;

`ifdef UART_RX_PARITY_EN
  assign par_en_s     = parity_en_i;
  assign parity_err_o = hold_err_r.parity;
`else
  logic unused_par_s;
  assign par_en_s     = 1'b0;
  assign parity_err_o = 1'b0;
  assign unused_par_s = parity_en_i ^ hold_err_r.parity;
`endif

  assign start_edge_s = (state_r == ST_IDLE) && rx_enable_i && rx_prev_r && !rx_sync_r;
  assign maj_tick_s   = tick_s && (samp_cnt_r == SAMP_C);
  assign bit_end_s    = tick_s && (samp_cnt_r == SAMP_LAST);
  // Third sample is the live synchronised line at the last vote tick
  assign maj_s        = (smp_a_r & smp_b_r) | (smp_a_r & rx_sync_r) | (smp_b_r & rx_sync_r);
  assign frame_done_s = (state_r == ST_STOP) && maj_tick_s && rx_enable_i;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk       (clk),
    .rstn      (rstn),
    .clk_div_i (clk_div_i),
    .clear_i   (start_edge_s),
    .tick_o    (tick_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic; disabling the receiver aborts any frame in progress
  always_comb begin
    state_s = state_r;
    if (!rx_enable_i) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   if (start_edge_s) state_s = ST_START; else state_s = ST_IDLE;
        ST_START: begin
          if (maj_tick_s && maj_s) state_s = ST_IDLE;
          else if (bit_end_s)      state_s = ST_DATA;
          else                     state_s = ST_START;
        end
        ST_DATA: begin
          if (bit_end_s && (bit_cnt_r == 3'd7)) state_s = par_en_r ? ST_PARITY : ST_STOP;
          else                                  state_s = ST_DATA;
        end
        ST_PARITY: if (bit_end_s) state_s = ST_STOP; else state_s = ST_PARITY;
        // Leave at the vote, not the bit end, so a back-to-back start edge is seen
        ST_STOP:   if (maj_tick_s) state_s = ST_IDLE; else state_s = ST_STOP;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // Line synchroniser and previous-sample register for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Bit-slot sampling, majority capture, data shift and parity tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      samp_cnt_r <= {SW{1'b0}};
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      smp_a_r    <= 1'b1;
      smp_b_r    <= 1'b1;
      par_en_r   <= 1'b0;
      par_err_r  <= 1'b0;
    end else begin
      if (state_r == ST_IDLE)  samp_cnt_r <= {SW{1'b0}};
      else if (tick_s)         samp_cnt_r <= (samp_cnt_r == SAMP_LAST) ? {SW{1'b0}} : samp_cnt_r + SAMP_ONE;
      if (state_r != ST_DATA)  bit_cnt_r <= 3'd0;
      else if (bit_end_s)      bit_cnt_r <= bit_cnt_r + 3'd1;
      if (tick_s && (samp_cnt_r == SAMP_A)) smp_a_r <= rx_sync_r;
      if (tick_s && (samp_cnt_r == SAMP_B)) smp_b_r <= rx_sync_r;
      if ((state_r == ST_DATA) && maj_tick_s) shift_r <= {maj_s, shift_r[7:1]};
      if ((state_r == ST_START) && (state_s == ST_DATA)) par_en_r <= par_en_s;
      if (state_r == ST_START) par_err_r <= 1'b0;
      else if ((state_r == ST_PARITY) && maj_tick_s) par_err_r <= even_par_err(shift_r, maj_s);
    end
  end

  // Holding register with handshake, break and overrun pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_r     <= 8'h00;
      hold_err_r <= '{parity: 1'b0, frame: 1'b0};
      valid_r    <= 1'b0;
      break_r    <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      break_r   <= frame_done_s && (shift_r == 8'h00) && !maj_s;
      overrun_r <= frame_done_s && valid_r && !ready_i;
      if (frame_done_s && (!valid_r || ready_i)) begin
        data_r            <= shift_r;
        hold_err_r.frame  <= !maj_s;
        hold_err_r.parity <= par_en_r & par_err_r;
        valid_r           <= 1'b1;
      end else if (valid_r && ready_i) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign data_o      = data_r;
  assign valid_o     = valid_r;
  assign frame_err_o = hold_err_r.frame;
  assign break_o     = break_r;
  assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames with hand-computed results plus
// randomized frames checked against a frame-level model (queue of expected
// bytes, expected break/overrun counts).
module tb_uart_rx_core;

  localparam int OVS   = 16;
  localparam int DIV_W = 32;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [DIV_W-1:0] clk_div_i = '0;
  logic             rx_enable_i = 1'b1;
  logic             parity_en_i = 1'b0;
  logic             rx_i = 1'b1;
  logic             ready_i = 1'b1;
  logic [7:0]       data_o;
  logic             valid_o, parity_err_o, frame_err_o, break_o, overrun_o;

  uart_rx_core #(.OVERSAMPLE(OVS), .DIV_W(DIV_W)) dut (
    .clk(clk), .rstn(rstn), .clk_div_i(clk_div_i), .rx_enable_i(rx_enable_i),
    .parity_en_i(parity_en_i), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
    .break_o(break_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic perr; logic ferr; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int exp_brk = 0, exp_ovr = 0, brk_seen = 0, ovr_seen = 0, vcount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Frame-level model: decode the transmitted bit list as the receiver must
  task automatic model_frame(input logic [7:0] d, input logic par_sent, input logic pbit, input logic stop);
    logic par_act, stop_eff, perr, ferr;
    par_act  = par_sent && PAR_BUILD;
    perr     = par_act ? ((^d) ^ pbit) : 1'b0;
    stop_eff = (par_sent && !par_act) ? pbit : stop;
    ferr     = !stop_eff;
    if (d == 8'h00 && !stop_eff) exp_brk++;
    if (q.size() != 0 && !ready_i) exp_ovr++;
    else q.push_back('{d: d, perr: perr, ferr: ferr});
  endtask

  function automatic int bitc();
    return OVS * (int'(clk_div_i) + 1);
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    wait_clks(bitc());
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_sent, input logic pbit, input logic stop);
    model_frame(d, par_sent, pbit, stop);
    parity_en_i = par_sent;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_sent) drive_bit(pbit);
    drive_bit(stop);
    rx_i = 1'b1;
    wait_clks(2 * bitc());
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!valid_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, valid_o, 1'b1);
  endtask

  // Release the held byte and require valid_o to be gone one cycle later
  task automatic release_held(input string name);
    @(posedge clk); #1 ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check(name, valid_o, 1'b0);
  endtask

  // Per-cycle compare against the model queue and reset-value checks
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        check("rst_valid", valid_o, 1'b0);
        check("rst_data", data_o, 8'h00);
        check("rst_perr", parity_err_o, 1'b0);
        check("rst_ferr", frame_err_o, 1'b0);
        check("rst_break", break_o, 1'b0);
        check("rst_overrun", overrun_o, 1'b0);
      end else begin
        if (break_o) brk_seen++;
        if (overrun_o) ovr_seen++;
        if (valid_o) begin
          vcount++;
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_valid: got data %0h want no valid", data_o);
          end else begin
            check("cmp_data", data_o, q[0].d);
            check("cmp_perr", parity_err_o, q[0].perr);
            check("cmp_ferr", frame_err_o, q[0].ferr);
            if (ready_i) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int b0, o0, v0;
    logic [7:0] d;
    // Reset state
    wait_clks(5);
    rstn = 1'b1;
    wait_clks(3);
    check("post_rst_valid", valid_o, 1'b0);

    // 0xA5, no parity
    ready_i = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_valid("a5_valid");
    check("a5_data", data_o, 8'hA5);
    check("a5_perr", parity_err_o, 1'b0);
    check("a5_ferr", frame_err_o, 1'b0);
    release_held("a5_drop");

    // 0x03 with parity bit 1, then 0
    ready_i = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    wait_valid("p1_valid");
    check("p1_data", data_o, 8'h03);
    check("p1_perr", parity_err_o, PAR_BUILD ? 1'b1 : 1'b0);
    check("p1_ferr", frame_err_o, 1'b0);
    release_held("p1_drop");
    ready_i = 1'b0;
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);
    wait_valid("p0_valid");
    check("p0_data", data_o, 8'h03);
    check("p0_perr", parity_err_o, 1'b0);
    check("p0_ferr", frame_err_o, PAR_BUILD ? 1'b0 : 1'b1);
    release_held("p0_drop");

    // Break
    ready_i = 1'b0;
    b0 = brk_seen;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    wait_valid("brk_valid");
    check("brk_data", data_o, 8'h00);
    check("brk_ferr", frame_err_o, 1'b1);
    release_held("brk_drop");
    check("brk_pulses", brk_seen - b0, 1);

    // Overrun
    ready_i = 1'b0;
    o0 = ovr_seen;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    wait_clks(4);
    check("ovr_pulses", ovr_seen - o0, 1);
    check("ovr_valid", valid_o, 1'b1);
    check("ovr_data", data_o, 8'h11);
    release_held("ovr_drop");

    // False start: 3 clk low pulse
    v0 = vcount;
    rx_i = 1'b0;
    wait_clks(3);
    rx_i = 1'b1;
    wait_clks(80);
    check("false_start_novalid", vcount - v0, 0);

    // Receiver disabled mid-frame
    v0 = vcount;
    d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx_enable_i = 1'b0;
    for (int i = 3; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    wait_clks(2 * bitc());
    rx_enable_i = 1'b1;
    wait_clks(4);
    check("en_drop_novalid", vcount - v0, 0);

    // Reset during data bit 4, then 0x5A
    d = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_i = d[4];
    wait_clks(bitc() / 2);
    rstn = 1'b0;
    wait_clks(4);
    rx_i = 1'b1;
    rstn = 1'b1;
    wait_clks(3 * bitc());
    v0 = vcount;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    wait_drain("rst_5a_drain");
    check("rst_5a_once", vcount - v0, 1);

    // Randomized frames
    for (int k = 0; k < 20; k++) begin
      clk_div_i = DIV_W'($urandom_range(0, 3));
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0));
      wait_drain("rnd_drain");
    end

    check("final_breaks", brk_seen, exp_brk);
    check("final_overruns", ovr_seen, exp_ovr);
    check("final_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter OVERSAMPLE, default 16: oversample ticks per bit; legal values are 8 and 16.
REQ-002 Parameter DIV_W, default 32: width of clk_div_i.
REQ-003 clk  input  1: clock.
REQ-004 rstn  input  1: reset, asynchronous, active-low.
REQ-005 clk_div_i  input  DIV_W: one oversample tick every clk_div_i+1 clk cycles.
REQ-006 rx_enable_i  input  1: receiver enable.
REQ-007 parity_en_i  input  1: an even-parity bit follows the data bits.
REQ-008 rx_i  input  1: asynchronous serial line; idles high.
REQ-009 data_o  output  8: received byte, held while valid_o is high.
REQ-010 valid_o  output  1: data_o and the error flags are valid.
REQ-011 ready_i  input  1: consumer accepts data_o.
REQ-012 parity_err_o  output  1: parity mismatch for the held byte.
REQ-013 frame_err_o  output  1: stop bit sampled low for the held byte.
REQ-014 break_o  output  1: one-cycle pulse when a break is detected.
REQ-015 overrun_o  output  1: one-cycle pulse when a completed byte is dropped.

Function
REQ-016 rx_i shall pass through a 2-flop synchroniser with reset value 1 before any use.
REQ-017 The tick counter shall count 0..clk_div_i, pulse a tick at terminal count, then reload; a new clk_div_i value takes effect at the next reload.
REQ-018 The FSM states shall be IDLE, START, DATA, PARITY and STOP.
REQ-019 In IDLE, a synchronised falling edge with rx_enable_i=1 shall clear the sample counter and go to START.
REQ-020 Bit value shall be the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-021 In START, a majority value of 1 is a false start and shall return the FSM to IDLE with no output; a value of 0 shall go to DATA after the bit.
REQ-022 DATA shall shift 8 bits LSB first, then go to PARITY if parity_en_i=1, otherwise to STOP.
REQ-023 PARITY shall record an error when XOR(data bits, parity bit) equals 1.
REQ-024 STOP shall return to IDLE right after the majority sample, not at the bit end, so the next start edge can be caught.
REQ-025 Frame completion shall set valid_o one clk after the stop-bit majority sample, loading data_o, parity_err_o and frame_err_o together.
REQ-026 A break is data=0x00 with stop=0; it shall pulse break_o, set frame_err_o and still present the byte.
REQ-027 valid_o shall stay high until a cycle with ready_i=1; data_o and the flags shall be stable while valid_o is high.
REQ-028 If a frame completes while valid_o=1 and ready_i=0: pulse overrun_o, drop the new byte, keep the held byte.
REQ-029 If a frame completes in the same cycle as valid_o&&ready_i: accept the old byte, load the new byte, no overrun.
REQ-030 parity_en_i shall be sampled at the START to DATA transition and held for the frame.
REQ-031 Deasserting rx_enable_i mid-frame shall force IDLE on the next clk, discard the partial byte and leave the holding register untouched.

Reset
REQ-032 Reset shall set: FSM=IDLE, counters=0, synchroniser=1, data_o=0x00, valid_o=0, parity_err_o=0, frame_err_o=0, break_o=0, overrun_o=0.
REQ-033 Reset asserted mid-frame shall abort the frame with no output after release.

Configuration
REQ-034 With macro UART_RX_PARITY_EN defined, PARITY state and parity_err_o shall behave as specified.
REQ-035 Without UART_RX_PARITY_EN, parity_en_i shall be ignored, PARITY shall never be entered and parity_err_o shall be tied 0; the port list shall be unchanged.

Structure
REQ-036 Package uart_pkg shall hold the FSM state enum, the OVERSAMPLE legal-value constants and a uart_rx_err_t struct {parity, frame}.
REQ-037 Tick generation shall be a sub-module uart_baud_tick (ports: clk, rstn, clk_div_i, clear_i, tick_o), cleared on each start edge so bit timing aligns to the edge.

Verification
REQ-038 clk_div_i=0, OVERSAMPLE=16, parity off, send 0xA5 with stop=1 -> valid_o high with data_o=0xA5, both errors 0; ready_i=1 drops valid_o the next cycle.
REQ-039 Parity on, send 0x03 with parity bit 1 -> data_o=0x03, parity_err_o=1; repeat with parity bit 0 -> parity_err_o=0.
REQ-040 Send 0x00 with stop=0 -> break_o pulses one cycle, frame_err_o=1, data_o=0x00.
REQ-041 ready_i=0, send 0x11 then 0x22 -> one overrun_o pulse, data_o stays 0x11; then ready_i=1 -> valid_o falls.
REQ-042 Hold the line low for 3 clk (clk_div_i=0), then high -> false start, no valid_o, FSM back in IDLE.
REQ-043 Assert rstn low during DATA bit 4, release, send 0x5A -> only 0x5A is delivered, outputs are at reset values during reset.
